// File: rtl/srambank_arb2.sv
// Round-robin 2-port sequencer for one 1024x80 sync SRAM bank; read data returns 1 (RSP_REG=0) or 2 (RSP_REG=1) cycles after grant.
// Requests are held off by deasserting req_ready; responses have no backpressure.
module srambank_arb2 #(
  parameter int AW      = 10,
  parameter int DW      = 80,
  parameter bit RSP_REG = 1'b0
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_write,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_data,

  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_write,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_data,

  output logic [AW-1:0] ADDRESS,
  output logic [DW-1:0] wd,
  output logic          banksel,
  output logic          read,
  output logic          write,
  input  logic [DW-1:0] dataout
);

  logic          prio_q;
  logic          gnt0;
  logic          gnt1;
  logic          gnt_any;
  logic          gnt_write;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q;
  logic          tag_vld_q;
  logic          tag_port_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = p0_req_valid & (~p1_req_valid | ~prio_q);
      gnt1 = p1_req_valid & (~p0_req_valid |  prio_q);
    end
  end

  assign gnt_any      = gnt0 | gnt1;
  assign gnt_write    = gnt0 ? p0_req_write : p1_req_write;
  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  assign banksel = gnt_any;
  assign read    = gnt_any & ~gnt_write;
  assign write   = gnt_any &  gnt_write;

  // Idle cycles replay the last granted address/data so the bank inputs stay quiet.
  assign ADDRESS = gnt0 ? p0_req_addr  : (gnt1 ? p1_req_addr  : addr_q);
  assign wd      = gnt0 ? p0_req_wdata : (gnt1 ? p1_req_wdata : wd_q);

  always_ff @(posedge clk) begin
    if (gnt_any) begin
      addr_q <= ADDRESS;
      wd_q   <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= 1'b0;
    end else begin
      if (gnt_any) prio_q <= gnt0;
      tag_vld_q  <= gnt_any & ~gnt_write;
      tag_port_q <= gnt1;
    end
  end

  generate
    if (RSP_REG) begin : g_rsp_reg
      logic          rsp_vld0_q;
      logic          rsp_vld1_q;
      logic [DW-1:0] rsp_data_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_vld0_q <= 1'b0;
          rsp_vld1_q <= 1'b0;
          rsp_data_q <= '0;
        end else begin
          rsp_vld0_q <= tag_vld_q & ~tag_port_q;
          rsp_vld1_q <= tag_vld_q &  tag_port_q;
          if (tag_vld_q) rsp_data_q <= dataout;
        end
      end

      assign p0_rsp_valid = rsp_vld0_q & ~reset;
      assign p1_rsp_valid = rsp_vld1_q & ~reset;
      assign p0_rsp_data  = rsp_data_q;
      assign p1_rsp_data  = rsp_data_q;
    end else begin : g_rsp_direct
      // Reset also masks a tag registered on the edge just before it took effect.
      assign p0_rsp_valid = tag_vld_q & ~tag_port_q & ~reset;
      assign p1_rsp_valid = tag_vld_q &  tag_port_q & ~reset;
      assign p0_rsp_data  = dataout;
      assign p1_rsp_data  = dataout;
    end
  endgenerate

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(read && write));
  a_one_gnt:    assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));

endmodule
